// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the immediate-generation decode stage.
package imm_gen_pkg;

    localparam int unsigned XLEN_MAX = 64;
    localparam int unsigned ILEN     = 32;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_FENCE   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    // Entry payload sized for the widest datapath; RV32 builds use the low half.
    typedef struct packed {
        logic [ILEN-1:0]     instr;
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] imm;
        imm_fmt_e            fmt;
        logic                illegal;
        logic [XLEN_MAX-1:0] target;
    } entry_t;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Handshake bus between fetch/instruction buffer, the imm-gen stage and register-read.
interface imm_gen_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned INST_WIDTH = 32
);
    import imm_gen_pkg::*;

    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [INST_WIDTH-1:0] in_instr;
    logic [XLEN-1:0]       in_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [INST_WIDTH-1:0] out_instr;
    logic [XLEN-1:0]       out_pc;
    logic [XLEN-1:0]       out_imm;
    imm_fmt_e              out_fmt;
    logic                  out_illegal;
    logic [XLEN-1:0]       out_target;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal, out_target
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal, out_target
    );
endinterface

// File: rtl/imm_decode.sv
// Combinational immediate extraction, format classification and PC-relative target.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [ILEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_e        fmt_o,
    output logic            illegal_o,
    output logic [XLEN-1:0] target_o
);
    logic [6:0] opc_c;
    logic [2:0] f3_c;
    logic       is_shift_c;
    logic       pc_rel_c;

    assign opc_c      = instr_i[6:0];
    assign f3_c       = instr_i[14:12];
    assign is_shift_c = (f3_c == 3'b001) || (f3_c == 3'b101);

    // Format/immediate select; bit 30 of shift forms is funct7, never immediate.
    always_comb begin
        imm_o     = '0;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        pc_rel_c  = 1'b0;
        if (instr_i[1:0] != 2'b11) begin
            illegal_o = 1'b1;
        end else begin
            case (opc_c)
                OPC_LOAD, OPC_JALR: begin
                    fmt_o = FMT_I;
                    imm_o = XLEN'($signed(instr_i[31:20]));
                end
                OPC_OPIMM: begin
                    if (is_shift_c) begin
                        fmt_o = FMT_SHAMT;
                        if (XLEN == 64) imm_o = XLEN'(instr_i[25:20]);
                        else            imm_o = XLEN'(instr_i[24:20]);
                    end else begin
                        fmt_o = FMT_I;
                        imm_o = XLEN'($signed(instr_i[31:20]));
                    end
                end
                OPC_OPIMM32: begin
                    if (XLEN != 64) begin
                        illegal_o = 1'b1;
                    end else if (is_shift_c) begin
                        fmt_o = FMT_SHAMT;
                        imm_o = XLEN'(instr_i[24:20]);
                    end else begin
                        fmt_o = FMT_I;
                        imm_o = XLEN'($signed(instr_i[31:20]));
                    end
                end
                OPC_STORE: begin
                    fmt_o = FMT_S;
                    imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
                end
                OPC_BRANCH: begin
                    fmt_o    = FMT_B;
                    imm_o    = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                              instr_i[11:8], 1'b0}));
                    pc_rel_c = 1'b1;
                end
                OPC_LUI: begin
                    fmt_o = FMT_U;
                    imm_o = XLEN'($signed({instr_i[31:12], 12'b0}));
                end
                OPC_AUIPC: begin
                    fmt_o    = FMT_U;
                    imm_o    = XLEN'($signed({instr_i[31:12], 12'b0}));
                    pc_rel_c = 1'b1;
                end
                OPC_JAL: begin
                    fmt_o    = FMT_J;
                    imm_o    = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                              instr_i[30:21], 1'b0}));
                    pc_rel_c = 1'b1;
                end
                OPC_OP, OPC_FENCE, OPC_SYSTEM: begin
                    fmt_o = FMT_NONE;
                end
                OPC_OP32: begin
                    illegal_o = (XLEN != 64);
                end
                default: begin
                    illegal_o = 1'b1;
                end
            endcase
        end
    end

    // Target wraps modulo 2^XLEN.
    assign target_o = pc_rel_c ? (pc_i + imm_o) : '0;

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a 2-entry skid buffer and flush.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned INST_WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    imm_gen_if.slave bus
);
    logic [XLEN-1:0] imm_c;
    logic [XLEN-1:0] target_c;
    imm_fmt_e        fmt_c;
    logic            illegal_c;

    entry_t dec_c;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_vld_q, main_vld_d;
    logic   skid_vld_q, skid_vld_d;
    logic   rdy_q;
    logic   in_ready_c;
    logic   accept_c;
    logic   pop_c;
    logic   unused_main_c;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_i   (ILEN'(bus.in_instr)),
        .pc_i      (bus.in_pc),
        .imm_o     (imm_c),
        .fmt_o     (fmt_c),
        .illegal_o (illegal_c),
        .target_o  (target_c)
    );

    // Pack the decoded incoming instruction into an entry.
    always_comb begin
        dec_c.instr   = ILEN'(bus.in_instr);
        dec_c.pc      = XLEN_MAX'(bus.in_pc);
        dec_c.imm     = XLEN_MAX'(imm_c);
        dec_c.fmt     = fmt_c;
        dec_c.illegal = illegal_c;
        dec_c.target  = XLEN_MAX'(target_c);
    end

    // rdy_q holds in_ready low until the first edge after reset release.
    assign in_ready_c = rdy_q && !skid_vld_q;
    assign accept_c   = bus.in_valid && in_ready_c;
    assign pop_c      = main_vld_q && bus.out_ready;

    // FIFO movement between input, skid and main; flush overrides everything.
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (pop_c) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = 1'b0;
            end
        end
        if (accept_c) begin
            if (!main_vld_q || (pop_c && !skid_vld_q)) begin
                main_d     = dec_c;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = dec_c;
                skid_vld_d = 1'b1;
            end
        end
        if (bus.flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end
    end

    // Entry storage with asynchronous clear of valids and payloads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= 1'b1;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = main_vld_q;
    assign bus.out_instr   = INST_WIDTH'(main_q.instr);
    assign bus.out_pc      = XLEN'(main_q.pc);
    assign bus.out_imm     = XLEN'(main_q.imm);
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_illegal = main_q.illegal;
    assign bus.out_target  = XLEN'(main_q.target);

    // Upper payload halves are constant zero in RV32 builds.
    assign unused_main_c = ^main_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed scoreboard bench for imm_gen_stage (RV32 instance plus an RV64 instance).
module tb_imm_gen_stage;
    import imm_gen_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tgt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    logic        hold_vld = 1'b0;
    logic [31:0] hold_instr;
    logic [31:0] hold_imm;
    logic [31:0] hold_pc;

    imm_gen_if #(.XLEN(32), .INST_WIDTH(32)) bus ();
    imm_gen_if #(.XLEN(64), .INST_WIDTH(32)) bus64 ();

    imm_gen_stage #(.XLEN(32), .INST_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    imm_gen_stage #(.XLEN(64), .INST_WIDTH(32)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction to the RV32 instance; expectation queued on acceptance.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [2:0] fmt, input logic ill, input logic [31:0] tgt);
        logic ok;
        int   n;
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = bus.in_ready;
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        if (ok) exp_q.push_back(exp_t'{instr, pc, imm, fmt, ill, tgt});
        else    check("accept_timeout", 64'(bus.in_ready), 64'd1);
    endtask

    // Single instruction through the RV64 instance with out_ready held high.
    task automatic send64(input string tag, input logic [31:0] instr, input logic [63:0] imm,
                          input logic [2:0] fmt, input logic ill, input logic [63:0] tgt);
        bus64.in_valid = 1'b1;
        bus64.in_instr = instr;
        bus64.in_pc    = 64'h1000;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(bus64.in_ready), 64'd1);
        tick();
        bus64.in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_valid"}, 64'(bus64.out_valid), 64'd1);
        check({tag, "_imm"}, bus64.out_imm, imm);
        check({tag, "_fmt"}, 64'(bus64.out_fmt), 64'(fmt));
        check({tag, "_illegal"}, 64'(bus64.out_illegal), 64'(ill));
        check({tag, "_target"}, bus64.out_target, tgt);
        tick();
    endtask

    // Output monitor: scoreboard compare on each pop, stability while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld && bus.out_valid) begin
                check("hold_instr", 64'(bus.out_instr), 64'(hold_instr));
                check("hold_imm", 64'(bus.out_imm), 64'(hold_imm));
                check("hold_pc", 64'(bus.out_pc), 64'(hold_pc));
            end
            hold_vld   = bus.out_valid && !bus.out_ready;
            hold_instr = bus.out_instr;
            hold_imm   = bus.out_imm;
            hold_pc    = bus.out_pc;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'(bus.out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_instr", 64'(bus.out_instr), 64'(e.instr));
                    check("out_pc", 64'(bus.out_pc), 64'(e.pc));
                    check("out_imm", 64'(bus.out_imm), 64'(e.imm));
                    check("out_fmt", 64'(bus.out_fmt), 64'(e.fmt));
                    check("out_illegal", 64'(bus.out_illegal), 64'(e.ill));
                    check("out_target", 64'(bus.out_target), 64'(e.tgt));
                end
            end
        end
    end

    initial begin
        bus.flush      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_instr   = '0;
        bus.in_pc      = '0;
        bus.out_ready  = 1'b0;
        bus64.flush    = 1'b0;
        bus64.in_valid = 1'b0;
        bus64.in_instr = '0;
        bus64.in_pc    = '0;
        bus64.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_imm", 64'(bus.out_imm), 64'd0);
        rst = 1'b0;
        #1;
        check("rel_in_ready_low", 64'(bus.in_ready), 64'd0);
        tick();
        check("rel_in_ready_high", 64'(bus.in_ready), 64'd1);

        // Decode patterns with free-flowing output
        bus.out_ready = 1'b1;
        send(32'hFFF00093, 32'h0, 32'hFFFFFFFF, 3'(FMT_I), 1'b0, 32'h0);
        @(negedge clk);
        check("latency_valid", 64'(bus.out_valid), 64'd1);
        tick();
        send(32'h12345037, 32'h4, 32'h12345000, 3'(FMT_U), 1'b0, 32'h0);
        send(32'hFE000EE3, 32'h100, 32'hFFFFFFFC, 3'(FMT_B), 1'b0, 32'h000000FC);
        send(32'h0080006F, 32'h200, 32'h8, 3'(FMT_J), 1'b0, 32'h208);
        send(32'h4030D093, 32'h204, 32'h3, 3'(FMT_SHAMT), 1'b0, 32'h0);
        send(32'h00001097, 32'h1000, 32'h1000, 3'(FMT_U), 1'b0, 32'h2000);
        send(32'hFE112E23, 32'h8, 32'hFFFFFFFC, 3'(FMT_S), 1'b0, 32'h0);
        send(32'hFFDFF06F, 32'h0, 32'hFFFFFFFC, 3'(FMT_J), 1'b0, 32'hFFFFFFFC);
        send(32'h00000033, 32'hC, 32'h0, 3'(FMT_NONE), 1'b0, 32'h0);
        send(32'h00000073, 32'h10, 32'h0, 3'(FMT_NONE), 1'b0, 32'h0);
        send(32'h0000001B, 32'h14, 32'h0, 3'(FMT_NONE), 1'b1, 32'h0);
        send(32'h00000010, 32'h18, 32'h0, 3'(FMT_NONE), 1'b1, 32'h0);
        send(32'h0000007F, 32'h1C, 32'h0, 3'(FMT_NONE), 1'b1, 32'h0);
        @(negedge clk);
        tick();

        // Backpressure: A held, B in skid, C stalled
        bus.out_ready = 1'b0;
        send(32'h00100093, 32'h300, 32'h1, 3'(FMT_I), 1'b0, 32'h0);
        send(32'h00200113, 32'h304, 32'h2, 3'(FMT_I), 1'b0, 32'h0);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00300193;
        bus.in_pc    = 32'h308;
        @(negedge clk);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        check("bp_out_instr", 64'(bus.out_instr), 64'h00100093);
        tick();
        bus.out_ready = 1'b1;
        send(32'h00300193, 32'h308, 32'h3, 3'(FMT_I), 1'b0, 32'h0);
        @(negedge clk);
        tick();
        @(negedge clk);
        check("bp_drained", 64'(bus.out_valid), 64'd0);
        tick();

        // Flush with both entries full and an input pending
        bus.out_ready = 1'b0;
        send(32'h00400213, 32'h400, 32'h4, 3'(FMT_I), 1'b0, 32'h0);
        send(32'h00500293, 32'h404, 32'h5, 3'(FMT_I), 1'b0, 32'h0);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00600313;
        bus.in_pc    = 32'h408;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_full_valid", 64'(bus.out_valid), 64'd0);
        check("flush_full_ready", 64'(bus.in_ready), 64'd1);
        tick();

        // Flush with main occupied and a simultaneous accept
        send(32'h00700393, 32'h500, 32'h7, 3'(FMT_I), 1'b0, 32'h0);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00800413;
        bus.in_pc    = 32'h504;
        @(negedge clk);
        check("flush_acc_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_acc_valid", 64'(bus.out_valid), 64'd0);
        tick();
        bus.out_ready = 1'b1;
        send(32'h00900493, 32'h600, 32'h9, 3'(FMT_I), 1'b0, 32'h0);
        @(negedge clk);
        check("post_flush_valid", 64'(bus.out_valid), 64'd1);
        tick();
        @(negedge clk);
        check("post_flush_alone", 64'(bus.out_valid), 64'd0);
        tick();

        // Asynchronous reset mid-stream
        bus.out_ready = 1'b0;
        send(32'h00A00513, 32'h700, 32'hA, 3'(FMT_I), 1'b0, 32'h0);
        send(32'hFE000EE3, 32'h704, 32'hFFFFFFFC, 3'(FMT_B), 1'b0, 32'h00000700);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_in_ready", 64'(bus.in_ready), 64'd0);
        check("arst_out_instr", 64'(bus.out_instr), 64'd0);
        check("arst_out_imm", 64'(bus.out_imm), 64'd0);
        check("arst_out_pc", 64'(bus.out_pc), 64'd0);
        check("arst_out_target", 64'(bus.out_target), 64'd0);
        exp_q.delete();
        tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_rel_ready_low", 64'(bus.in_ready), 64'd0);
        tick();
        check("arst_rel_ready_high", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        send(32'h0080006F, 32'h800, 32'h8, 3'(FMT_J), 1'b0, 32'h808);
        @(negedge clk);
        check("arst_latency_valid", 64'(bus.out_valid), 64'd1);
        tick();

        // RV64 instance
        send64("rv64_srli63", 32'h03F0D093, 64'd63, 3'(FMT_SHAMT), 1'b0, 64'h0);
        send64("rv64_addiw", 32'h0010009B, 64'd1, 3'(FMT_I), 1'b0, 64'h0);
        send64("rv64_slliw", 32'h0230909B, 64'd3, 3'(FMT_SHAMT), 1'b0, 64'h0);
        send64("rv64_op32", 32'h0000003B, 64'd0, 3'(FMT_NONE), 1'b0, 64'h0);
        send64("rv64_auipc", 32'h80000097, 64'hFFFFFFFF80000000, 3'(FMT_U), 1'b0,
               64'hFFFFFFFF80001000);
        send64("rv64_addi", 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'(FMT_I), 1'b0, 64'h0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered, handshaked immediate-generation stage for the decode pipeline, parametrised for RV32/RV64.
- Extracts and sign-extends the immediate for every base-ISA format, including U-type and shift-amount forms.
- Classifies the format, flags illegal encodings and precomputes the PC-relative target.
- Sits between fetch/instruction buffer and register-read.
- A 2-entry skid buffer gives full throughput under backpressure; flush drops in-flight entries.

Parameters:
XLEN, 32, datapath/immediate/PC width; legal values 32 or 64.
INST_WIDTH, 32, instruction width; fixed at 32, no compressed support.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept
in_instr  in  INST_WIDTH  instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts
out_instr  out  INST_WIDTH  passthrough instruction
out_pc  out  XLEN  passthrough PC
out_imm  out  XLEN  decoded immediate
out_fmt  out  3  imm_fmt_e: NONE=0, I=1, S=2, B=3, U=4, J=5, SHAMT=6
out_illegal  out  1  unrecognised opcode or instr[1:0]!=2'b11
out_target  out  XLEN  pc+imm for B/J/AUIPC, else 0

Behaviour:
- Reset: rst high asynchronously clears both entry valids and zeroes all payload registers. While rst is high: out_valid=0, in_ready=0, all outputs 0. in_ready rises the first cycle after rst deasserts.
- Storage: main register (drives outputs) plus skid register. in_ready = !skid_valid. Decode happens before registration, so out_* carries the decode of the stored instruction. Latency 1 cycle; throughput 1/cycle.
- Transfer rules:
  - Accept when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - If main is empty, or being popped, the incoming entry goes to main; otherwise it goes to skid.
  - On pop with skid valid, skid moves to main.
  - Order strictly FIFO.
  - Simultaneous accept and pop with both entries full cannot occur because in_ready=0.
- Flush: on a clock edge with flush high, both valids clear. An input accepted in the same cycle is discarded. flush beats accept and pop. in_ready is unaffected combinationally.
- Output stability: while out_valid && !out_ready, all out_* hold stable.
- Decode (sign bit is instr[31], extended to XLEN):
  - I: opcode 0000011, 1100111, and 0010011 with funct3 not 001/101. imm = sext(instr[31:20]).
  - SHAMT: 0010011 with funct3 001/101. imm = zext(instr[24:20]) when XLEN=32, zext(instr[25:20]) when XLEN=64. instr[30] (SRAI) is never part of imm.
  - RV64 only: 0011011 uses I/SHAMT rules with a 5-bit shamt.
  - S: 0100011. imm = sext({instr[31:25], instr[11:7]}).
  - B: 1100011. imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U: 0110111 (LUI), 0010111 (AUIPC). imm = sext({instr[31:12], 12'b0}).
  - J: 1101111. imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - NONE, imm=0, legal: 0110011, 0001111, 1110011; plus 0111011 when XLEN=64.
  - Any other opcode, or instr[1:0]!=11: fmt=NONE, imm=0, target=0, out_illegal=1. RV64-only opcodes are illegal when XLEN=32.
- out_target: pc+imm, modulo 2^XLEN (wrap, no flag), for fmt B, J and AUIPC; LUI and all others give 0.

Decomposition:
- imm_gen_pkg holds:
  - imm_fmt_e enum (3-bit);
  - opcode localparams (OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP32, OPC_FENCE, OPC_SYSTEM);
  - a packed struct for the entry payload (instr, pc, imm, fmt, illegal, target).
- One sub-module: imm_decode, purely combinational, parametrised by XLEN. Inputs instr and pc; outputs imm, fmt, illegal, target. imm_gen_stage instantiates it once, on the input side, and owns only the skid and handshake logic.

Test Plan:
- ADDI 0xFFF00093, pc 0x0, out_ready=1 → next cycle out_valid=1, imm=0xFFFFFFFF, fmt=I, illegal=0, target=0. Then LUI 0x12345037 → imm=0x12345000, fmt=U, target=0.
- BEQ 0xFE000EE3 at pc 0x100 → imm=0xFFFFFFFC, fmt=B, target=0x000000FC. JAL 0x0080006F at pc 0x200 → imm=8, fmt=J, target=0x208.
- SRAI 0x4030D093 → fmt=SHAMT, imm=3 (bit 30 excluded). With XLEN=64, 0x03F0D093 → imm=63, and opcode 0011011 is legal. With XLEN=32, opcode 0011011 → illegal=1.
- Backpressure: out_ready=0, present A, B, C back-to-back → A held on outputs, B in skid, in_ready=0 while C waits. Raise out_ready → outputs A, B, C on consecutive cycles, no loss or duplication.
- Flush with both entries full plus a simultaneous accept → next cycle out_valid=0 and in_ready=1. Next instruction appears alone after 1 cycle.
- Assert rst mid-stream (asynchronously, between edges) → out_valid and all outputs go to 0 immediately. After release, first accepted instruction emerges with 1-cycle latency. Also: 0x00000013 with bits [1:0]=00 changed → illegal=1, imm=0.
